sram_fifo_ctrl: RTL



---
 rtl/sram_fifo_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sram_fifo_ctrl.sv
// Purpose: valid/ready streaming FIFO built on a single-port SRAM with 1-cycle registered read latency.
// Latency: push-to-pop on an empty FIFO is 3 cycles (write, read, capture); data always goes through the SRAM.
// Backpressure: in_ready_o drops when the SRAM is full or a starving read owns the port; output stalls hold a 2-entry buffer.
module sram_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int SRAM_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid_i,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    output logic                    in_ready_o,
    output logic                    out_valid_o,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    input  logic                    out_ready_i,
    output logic [ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [DATA_WIDTH-1:0]   sram_wdata_o,
    output logic                    sram_we_o,
    input  logic [DATA_WIDTH-1:0]   sram_rdata_i,
    output logic [ADDR_WIDTH+1:0]   count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int CW = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(SRAM_DEPTH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   sram_cnt_q, sram_cnt_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [DATA_WIDTH-1:0] ob0_q, ob0_d;
    logic [DATA_WIDTH-1:0] ob1_q, ob1_d;
    logic [1:0]            ob_cnt_q, ob_cnt_d;
    logic                  out_valid_q;

    logic [1:0] occ;
    logic       sram_nonempty;
    logic       sram_full;
    logic       starving;
    logic       wr_en;
    logic       rd_en;
    logic       pop;
    logic       cap;

    // Words already committed to the output path (buffered or being read).
    assign occ           = ob_cnt_q + {1'b0, rd_inflight_q};
    assign sram_nonempty = (sram_cnt_q != '0);
    assign sram_full     = (sram_cnt_q == DEPTH_C);
    // An empty output path with data in the SRAM must read first, or output throughput collapses.
    assign starving      = (occ == 2'd0) && sram_nonempty;

    assign in_ready_o    = rst_n && !sram_full && !starving;
    assign wr_en         = in_valid_i && in_ready_o;
    // Reads are limited so the 2-entry buffer can always absorb every in-flight word.
    assign rd_en         = !wr_en && sram_nonempty && (occ < 2'd2);

    assign pop           = out_valid_q && out_ready_i;
    assign cap           = rd_inflight_q;

    assign sram_we_o     = wr_en;
    assign sram_addr_o   = wr_en ? wptr_q : rptr_q;
    assign sram_wdata_o  = in_data_i;

    assign out_valid_o   = out_valid_q;
    assign out_data_o    = ob0_q;

    assign count_o       = CW'(sram_cnt_q) + CW'(rd_inflight_q) + CW'(ob_cnt_q);
    assign full_o        = sram_full;
    assign empty_o       = (count_o == '0);

    // Pointer, SRAM occupancy and in-flight read bookkeeping.
    always_comb begin
        wptr_d        = wr_en ? (wptr_q + ADDR_WIDTH'(1)) : wptr_q;
        rptr_d        = rd_en ? (rptr_q + ADDR_WIDTH'(1)) : rptr_q;
        sram_cnt_d    = sram_cnt_q;
        if (wr_en) begin
            sram_cnt_d = sram_cnt_q + 1'b1;
        end else if (rd_en) begin
            sram_cnt_d = sram_cnt_q - 1'b1;
        end
        rd_inflight_d = rd_en;
    end

    // Output buffer: captured read data enters at the tail, pops shift the tail to the head.
    always_comb begin
        ob0_d    = ob0_q;
        ob1_d    = ob1_q;
        ob_cnt_d = ob_cnt_q;
        case ({pop, cap})
            2'b01: begin
                if (ob_cnt_q == 2'd0) begin
                    ob0_d = sram_rdata_i;
                end else begin
                    ob1_d = sram_rdata_i;
                end
                ob_cnt_d = ob_cnt_q + 2'd1;
            end
            2'b10: begin
                // Head keeps its last value when the buffer drains.
                if (ob_cnt_q == 2'd2) begin
                    ob0_d = ob1_q;
                end
                ob_cnt_d = ob_cnt_q - 2'd1;
            end
            2'b11: begin
                if (ob_cnt_q == 2'd1) begin
                    ob0_d = sram_rdata_i;
                end else begin
                    ob0_d = ob1_q;
                    ob1_d = sram_rdata_i;
                end
            end
            default: ;
        endcase
    end

    // State registers; reset drops any in-flight read so stale SRAM data is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            sram_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
            ob0_q         <= '0;
            ob1_q         <= '0;
            ob_cnt_q      <= 2'd0;
            out_valid_q   <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            sram_cnt_q    <= sram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            ob0_q         <= ob0_d;
            ob1_q         <= ob1_d;
            ob_cnt_q      <= ob_cnt_d;
            out_valid_q   <= (ob_cnt_d != 2'd0);
        end
    end

endmodule
